// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned MOUSE_W    = 25;
  localparam int unsigned STATUS_LSB = 0;
  localparam int unsigned X_LSB      = 8;
  localparam int unsigned Y_LSB      = 16;
  localparam int unsigned TOGGLE_BIT = 24;
  localparam int unsigned SYNC_BIT   = 3;

  // Odd parity holds when data bits plus parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [BYTE_W-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a FILT-sample stability filter for one PS/2 line.
module ps2_line_filter #(
  parameter int unsigned FILT = 8
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int unsigned CW = (FILT < 2) ? 1 : $clog2(FILT + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  // The level only moves after FILT consecutive synchronised samples disagree with it.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      level  <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (sync_q[1] == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILT - 1)) begin
        level <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: bit-level FSM, 3-byte packet assembly and stall timeout.
module ps2_mouse_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILT    = 8,
  parameter int unsigned TIMEOUT = 64000
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  output logic [MOUSE_W-1:0] ps2_mouse,
  output logic               frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic clk_f;
  logic data_f;
  logic clk_prev_q;
  logic fall;
  logic timeout;
  logic byte_ok;

  ps2_state_e          state_q, state_d, cur;
  logic [2:0]          bit_q, bit_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic [1:0]          idx_q, idx_d;
  logic [BYTE_W-1:0]   sh0_q, sh0_d;
  logic [BYTE_W-1:0]   sh1_q, sh1_d;
  logic [MOUSE_W-1:0]  mouse_q, mouse_d;
  logic                err_q, err_d;
  logic [TW-1:0]       idle_q, idle_d;

  ps2_line_filter #(.FILT(FILT)) u_clk_filt (
    .clk_sys (clk_sys),
    .reset   (reset),
    .raw     (ps2_clk),
    .level   (clk_f)
  );

  ps2_line_filter #(.FILT(FILT)) u_data_filt (
    .clk_sys (clk_sys),
    .reset   (reset),
    .raw     (ps2_data),
    .level   (data_f)
  );

  assign fall    = clk_prev_q & ~clk_f;
  assign timeout = (idle_q == TW'(TIMEOUT));
  assign byte_ok = data_f & odd_parity_ok(shift_q, par_q);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      idx_q      <= '0;
      sh0_q      <= '0;
      sh1_q      <= '0;
      mouse_q    <= '0;
      err_q      <= 1'b0;
      idle_q     <= '0;
    end else begin
      clk_prev_q <= clk_f;
      state_q    <= state_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      idx_q      <= idx_d;
      sh0_q      <= sh0_d;
      sh1_q      <= sh1_d;
      mouse_q    <= mouse_d;
      err_q      <= err_d;
      idle_q     <= idle_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    idx_d   = idx_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    mouse_d = mouse_q;
    err_d   = 1'b0;
    idle_d  = idle_q;
    cur     = state_q;

    if (fall) begin
      idle_d = '0;
    end else if (!timeout) begin
      idle_d = idle_q + TW'(1);
    end

    // A timeout resynchronises before any edge in the same cycle is handled.
    if (timeout) begin
      cur   = ST_IDLE;
      idx_d = '0;
    end
    state_d = cur;

    if (fall) begin
      case (cur)
        ST_IDLE: begin
          if (!data_f) begin
            state_d = ST_DATA;
            bit_d   = '0;
          end
        end
        ST_DATA: begin
          shift_d = {data_f, shift_q[BYTE_W-1:1]};
          if (bit_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
        ST_PARITY: begin
          par_d   = data_f;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!byte_ok) begin
            err_d = 1'b1;
            idx_d = '0;
          end else begin
            case (idx_q)
              2'd0: begin
                if (shift_q[SYNC_BIT]) begin
                  sh0_d = shift_q;
                  idx_d = 2'd1;
                end else begin
                  err_d = 1'b1;
                end
              end
              2'd1: begin
                sh1_d = shift_q;
                idx_d = 2'd2;
              end
              2'd2: begin
                mouse_d[STATUS_LSB +: BYTE_W] = sh0_q;
                mouse_d[X_LSB +: BYTE_W]      = sh1_q;
                mouse_d[Y_LSB +: BYTE_W]      = shift_q;
                mouse_d[TOGGLE_BIT]           = ~mouse_q[TOGGLE_BIT];
                idx_d                         = '0;
              end
              default: idx_d = '0;
            endcase
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign ps2_mouse = mouse_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Directed and randomised PS/2 traffic checked against a byte-level packet model.
module tb_ps2_mouse_rx;

  localparam int unsigned FILT    = 8;
  localparam int unsigned TIMEOUT = 2000;
  localparam int unsigned HALF    = 40;

  logic        clk_sys  = 1'b0;
  logic        reset    = 1'b1;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [24:0] ps2_mouse;
  logic        frame_err;

  int tests    = 0;
  int fails    = 0;
  int err_seen = 0;
  int err_exp  = 0;

  logic [24:0] exp_mouse = '0;
  logic [7:0]  pkt[$];

  always #5 clk_sys = ~clk_sys;

  ps2_mouse_rx #(.FILT(FILT), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_mouse (ps2_mouse),
    .frame_err (frame_err)
  );

  always @(posedge clk_sys) if (frame_err === 1'b1) err_seen++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Packet rules at byte granularity: accepted bytes queue up, three make a packet.
  task automatic model_byte(input logic [7:0] b, input bit ok, output bit err);
    err = 1'b0;
    if (!ok) begin
      err = 1'b1;
      pkt.delete();
    end else if (pkt.size() == 0 && !b[3]) begin
      err = 1'b1;
    end else begin
      pkt.push_back(b);
      if (pkt.size() == 3) begin
        exp_mouse = {~exp_mouse[24], pkt[2], pkt[1], pkt[0]};
        pkt.delete();
      end
    end
  endtask

  task automatic idle(input int n);
    ps2_data = 1'b1;
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic clock_bit(input bit b, input bit glitch);
    ps2_data = b;
    repeat (HALF / 2) @(negedge clk_sys);
    if (glitch) begin
      ps2_clk = 1'b0;
      repeat (FILT - 2) @(negedge clk_sys);
      ps2_clk = 1'b1;
      repeat (HALF / 2 - (FILT - 2)) @(negedge clk_sys);
    end else begin
      repeat (HALF / 2) @(negedge clk_sys);
    end
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk_sys);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit glitch, input int nbits);
    logic [10:0] bits;
    logic [24:0] prev;
    bit          err;
    bits = {1'b1, (bad_par ? ^b : ~^b), b, 1'b0};
    for (int i = 0; i < 10 && i < nbits; i++) clock_bit(bits[i], glitch);
    if (nbits < 11) return;
    ps2_data = ~bad_stop;
    repeat (HALF) @(negedge clk_sys);
    ps2_clk = 1'b0;
    prev = exp_mouse;
    model_byte(b, !bad_par && !bad_stop, err);
    if (err) err_exp++;
    repeat (FILT + 2) @(posedge clk_sys);
    #1;
    chk("mouse_hold", 32'(ps2_mouse), 32'(prev));
    chk("err_early", 32'(frame_err), 32'(0));
    @(posedge clk_sys);
    #1;
    chk("mouse_update", 32'(ps2_mouse), 32'(exp_mouse));
    chk("err_pulse", 32'(frame_err), 32'(err));
    @(posedge clk_sys);
    #1;
    chk("err_clear", 32'(frame_err), 32'(0));
    @(negedge clk_sys);
    repeat (HALF - FILT - 5) @(negedge clk_sys);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    chk("err_count", 32'(err_seen), 32'(err_exp));
  endtask

  task automatic send_ok(input logic [7:0] b, input bit glitch);
    send_frame(b, 1'b0, 1'b0, glitch, 11);
    idle(30);
  endtask

  initial begin
    logic [7:0] rb;
    bit         bp, bs, gl;

    repeat (4) @(negedge clk_sys);
    chk("reset_mouse", 32'(ps2_mouse), 32'(0));
    chk("reset_err", 32'(frame_err), 32'(0));
    reset = 1'b0;
    idle(10);

    // basic packet
    send_ok(8'h09, 1'b0); send_ok(8'h05, 1'b0); send_ok(8'hFB, 1'b0);
    chk("pkt1_value", 32'(ps2_mouse), 32'h1FB0509);

    // bad parity on byte 1 drops the partial packet
    send_ok(8'h0D, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0, 1'b0, 11); idle(30);
    send_ok(8'h08, 1'b0); send_ok(8'h01, 1'b0); send_ok(8'h02, 1'b0);
    chk("pkt2_value", 32'(ps2_mouse), 32'h0020108);

    // sync error on a leading byte without bit3
    send_ok(8'h00, 1'b0);
    send_ok(8'h18, 1'b0); send_ok(8'h10, 1'b0); send_ok(8'hF0, 1'b0);
    chk("pkt3_value", 32'(ps2_mouse), 32'h1F01018);

    // stall between bytes resynchronises
    send_ok(8'h09, 1'b0); send_ok(8'h05, 1'b0);
    idle(2 * TIMEOUT);
    pkt.delete();
    chk("stall_hold", 32'(ps2_mouse), 32'h1F01018);
    send_ok(8'h0A, 1'b0); send_ok(8'h03, 1'b0); send_ok(8'h04, 1'b0);
    chk("pkt4_value", 32'(ps2_mouse), 32'h004030A);

    // stall in the middle of a byte
    send_ok(8'h29, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 4);
    idle(TIMEOUT + 100);
    pkt.delete();
    send_ok(8'h19, 1'b0); send_ok(8'h22, 1'b0); send_ok(8'h33, 1'b0);
    chk("pkt5_value", 32'(ps2_mouse), 32'h1332219);

    // clock glitches shorter than the filter
    send_ok(8'h09, 1'b1); send_ok(8'h7F, 1'b1); send_ok(8'h80, 1'b1);
    chk("glitch_value", 32'(ps2_mouse), 32'h0807F09);

    // reset in the middle of byte 1
    send_ok(8'h09, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0, 1'b0, 7);
    ps2_data = 1'b1;
    @(negedge clk_sys);
    reset = 1'b1;
    @(posedge clk_sys);
    #1;
    chk("midreset_mouse", 32'(ps2_mouse), 32'(0));
    chk("midreset_err", 32'(frame_err), 32'(0));
    @(negedge clk_sys);
    reset = 1'b0;
    exp_mouse = '0;
    pkt.delete();
    idle(20);
    send_ok(8'h0C, 1'b0); send_ok(8'h00, 1'b0); send_ok(8'h00, 1'b0);
    chk("postreset_value", 32'(ps2_mouse), 32'h100000C);
    chk("postreset_toggle", 32'(ps2_mouse[24]), 32'(1));

    // randomised byte stream with errors, glitches and stalls
    for (int i = 0; i < 40; i++) begin
      rb = 8'($urandom);
      if (pkt.size() == 0 && $urandom_range(0, 5) != 0) rb[3] = 1'b1;
      bp = ($urandom_range(0, 9) == 0);
      bs = !bp && ($urandom_range(0, 14) == 0);
      gl = ($urandom_range(0, 3) == 0);
      send_frame(rb, bp, bs, gl, 11);
      if ($urandom_range(0, 11) == 0) begin
        idle(TIMEOUT + 200);
        pkt.delete();
      end else begin
        idle(int'($urandom_range(5, 300)));
      end
    end
    chk("random_final", 32'(ps2_mouse), 32'(exp_mouse));
    chk("random_errs", 32'(err_seen), 32'(err_exp));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
